operand_fetch_unit: RTL and testbench

- Initiator side of the 16x32 register file. Drives the file's two synchronous read ports and its single write port.
- Accepts operand requests (rs1, rs2, tag) from the issue logic and waits out the file's one-cycle registered read latency.
- Corrects read-during-write staleness by forwarding, then presents operands to the compute datapath over a valid/ready handshake.
- Held operands stay coherent with later writebacks.

---
 rtl/operand_fetch_unit_pkg.sv | 21 ++
 rtl/operand_fetch_unit_fwd_mux.sv | 34 +++
 rtl/operand_fetch_unit.sv | 163 ++++++++++++++++
 tb/tb_operand_fetch_unit.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/operand_fetch_unit_pkg.sv
// Shared definitions for the operand fetch unit: default widths, FSM encoding
// and the request record held between accept and operand delivery.
package operand_fetch_unit_pkg;

    localparam int OFU_DATA_W = 32;
    localparam int OFU_ADDR_W = 4;
    localparam int OFU_TAG_W  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        VALID = 2'd2
    } state_t;

    typedef struct packed {
        logic [OFU_ADDR_W-1:0] rs1;
        logic [OFU_ADDR_W-1:0] rs2;
        logic [OFU_TAG_W-1:0]  tag;
    } req_t;

endpackage

// File: rtl/operand_fetch_unit_fwd_mux.sv
// Per-operand source select: live writeback, value saved at accept time,
// or register-file read data. A zero-register source overrides everything.
module ofu_fwd_mux
    import operand_fetch_unit_pkg::*;
#(
    parameter int DATA_W = OFU_DATA_W,
    parameter int ADDR_W = OFU_ADDR_W
) (
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [ADDR_W-1:0] rs,
    input  logic              fwd,
    input  logic [DATA_W-1:0] saved,
    input  logic [DATA_W-1:0] file_data,
    input  logic              zero,
    output logic              wb_hit,
    output logic [DATA_W-1:0] data
);

    always_comb begin
        wb_hit = wb_valid && (wb_addr == rs) && !zero;
        if (zero) begin
            data = '0;
        end else if (wb_hit) begin
            data = wb_data;
        end else if (fwd) begin
            data = saved;
        end else begin
            data = file_data;
        end
    end

endmodule

// File: rtl/operand_fetch_unit.sv
// Operand fetch unit: reads two sources from a 1-cycle-latency register file,
// forwards in-flight writebacks, and keeps held operands coherent.
// Optional feature macro: OFU_ZERO_REG_EN (register 0 hardwired to zero).
module operand_fetch_unit
    import operand_fetch_unit_pkg::*;
#(
    parameter int DATA_W = OFU_DATA_W,
    parameter int ADDR_W = OFU_ADDR_W,
    parameter int TAG_W  = OFU_TAG_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_rs1,
    input  logic [ADDR_W-1:0] req_rs2,
    input  logic [TAG_W-1:0]  req_tag,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic [ADDR_W-1:0] rf_read_addr1,
    output logic [ADDR_W-1:0] rf_read_addr2,
    input  logic [DATA_W-1:0] rf_read_data1,
    input  logic [DATA_W-1:0] rf_read_data2,
    output logic [ADDR_W-1:0] rf_write_addr,
    output logic [DATA_W-1:0] rf_write_data,
    output logic              rf_write_enable,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    output logic [TAG_W-1:0]  op_tag
);

    state_t            state;
    state_t            next_state;
    req_t              held;
    logic              fwd1;
    logic              fwd2;
    logic [DATA_W-1:0] saved1;
    logic [DATA_W-1:0] saved2;
    logic              accept;
    logic              wb_match1;
    logic              wb_match2;
    logic              zero1;
    logic              zero2;
    logic              wb_to_zero;
    logic              hit_a;
    logic              hit_b;
    logic [DATA_W-1:0] sel_a;
    logic [DATA_W-1:0] sel_b;

`ifdef OFU_ZERO_REG_EN
    assign wb_to_zero = (wb_addr == '0);
    assign zero1      = (held.rs1 == '0);
    assign zero2      = (held.rs2 == '0);
`else
    assign wb_to_zero = 1'b0;
    assign zero1      = 1'b0;
    assign zero2      = 1'b0;
`endif

    assign rf_write_addr   = wb_addr;
    assign rf_write_data   = wb_data;
    assign rf_write_enable = wb_valid & rst_n & ~wb_to_zero;
    assign rf_read_addr1   = req_rs1;
    assign rf_read_addr2   = req_rs2;

    // Writes in the accept cycle commit after the file has already read the old value.
    assign wb_match1 = wb_valid && (wb_addr == req_rs1);
    assign wb_match2 = wb_valid && (wb_addr == req_rs2);
    assign accept    = req_valid && req_ready;

    always_comb begin
        next_state = state;
        req_ready  = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) next_state = FETCH;
            end
            FETCH: begin
                next_state = VALID;
            end
            VALID: begin
                req_ready = op_ready;
                if (op_ready) next_state = req_valid ? FETCH : IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    ofu_fwd_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fwd_a (
        .wb_valid  (wb_valid),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .rs        (held.rs1),
        .fwd       (fwd1),
        .saved     (saved1),
        .file_data (rf_read_data1),
        .zero      (zero1),
        .wb_hit    (hit_a),
        .data      (sel_a)
    );

    ofu_fwd_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fwd_b (
        .wb_valid  (wb_valid),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .rs        (held.rs2),
        .fwd       (fwd2),
        .saved     (saved2),
        .file_data (rf_read_data2),
        .zero      (zero2),
        .wb_hit    (hit_b),
        .data      (sel_b)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            held     <= '0;
            fwd1     <= 1'b0;
            fwd2     <= 1'b0;
            saved1   <= '0;
            saved2   <= '0;
            op_valid <= 1'b0;
            op_a     <= '0;
            op_b     <= '0;
            op_tag   <= '0;
        end else begin
            state <= next_state;
            if (accept) begin
                held.rs1 <= req_rs1;
                held.rs2 <= req_rs2;
                held.tag <= req_tag;
                fwd1     <= wb_match1;
                fwd2     <= wb_match2;
                if (wb_match1) saved1 <= wb_data;
                if (wb_match2) saved2 <= wb_data;
            end
            case (state)
                FETCH: begin
                    op_a     <= sel_a;
                    op_b     <= sel_b;
                    op_tag   <= held.tag;
                    op_valid <= 1'b1;
                end
                VALID: begin
                    // Held operands track later writebacks to their source registers.
                    if (hit_a) op_a <= wb_data;
                    if (hit_b) op_b <= wb_data;
                    if (op_ready) op_valid <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_operand_fetch_unit.sv
// Bench for operand_fetch_unit: a register-file model on the rf ports, directed
// scenarios, then random traffic against an architectural-register reference.
module tb_operand_fetch_unit;
    import operand_fetch_unit_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_rs1;
    logic [3:0]  req_rs2;
    logic [3:0]  req_tag;
    logic        wb_valid;
    logic [3:0]  wb_addr;
    logic [31:0] wb_data;
    logic [3:0]  rf_read_addr1;
    logic [3:0]  rf_read_addr2;
    logic [31:0] rf_read_data1;
    logic [31:0] rf_read_data2;
    logic [3:0]  rf_write_addr;
    logic [31:0] rf_write_data;
    logic        rf_write_enable;
    logic        op_valid;
    logic        op_ready;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [3:0]  op_tag;

    int checks   = 0;
    int failures = 0;

    // Reference: architectural register values, plus the delivery schedule.
    logic [31:0] arch [16];
    req_t        exp_q [$];
    req_t        m_req;
    logic        m_valid;
    logic        m_pending;

    logic [31:0] rf_mem [16];

    operand_fetch_unit dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_rs1         (req_rs1),
        .req_rs2         (req_rs2),
        .req_tag         (req_tag),
        .wb_valid        (wb_valid),
        .wb_addr         (wb_addr),
        .wb_data         (wb_data),
        .rf_read_addr1   (rf_read_addr1),
        .rf_read_addr2   (rf_read_addr2),
        .rf_read_data1   (rf_read_data1),
        .rf_read_data2   (rf_read_data2),
        .rf_write_addr   (rf_write_addr),
        .rf_write_data   (rf_write_data),
        .rf_write_enable (rf_write_enable),
        .op_valid        (op_valid),
        .op_ready        (op_ready),
        .op_a            (op_a),
        .op_b            (op_b),
        .op_tag          (op_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file: synchronous read-before-write, one cycle latency.
    always @(posedge clk) begin
        rf_read_data1 <= rf_mem[rf_read_addr1];
        rf_read_data2 <= rf_mem[rf_read_addr2];
        if (rf_write_enable) rf_mem[rf_write_addr] <= rf_write_data;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // One cycle: check registered outputs, drive inputs, check combinational
    // outputs, advance the reference, wait for the next negedge.
    task automatic step(input logic rv, input logic [3:0] r1, input logic [3:0] r2,
                        input logic [3:0] tg, input logic wv, input logic [3:0] wa,
                        input logic [31:0] wd, input logic ordy);
        logic m_ready;
        logic acc;
        logic exp_we;
        check("op_valid", {31'd0, op_valid}, {31'd0, m_valid});
        if (m_valid) begin
            check("op_a", op_a, arch[m_req.rs1]);
            check("op_b", op_b, arch[m_req.rs2]);
            check("op_tag", {28'd0, op_tag}, {28'd0, m_req.tag});
        end
        req_valid = rv;
        req_rs1   = r1;
        req_rs2   = r2;
        req_tag   = tg;
        wb_valid  = wv;
        wb_addr   = wa;
        wb_data   = wd;
        op_ready  = ordy;
        #1;
        m_ready = !m_pending && (!m_valid || ordy);
        exp_we  = wv;
`ifdef OFU_ZERO_REG_EN
        if (wa == 4'd0) exp_we = 1'b0;
`endif
        check("req_ready", {31'd0, req_ready}, {31'd0, m_ready});
        check("rf_we", {31'd0, rf_write_enable}, {31'd0, exp_we});
        if (wv) check("rf_wdata", rf_write_data, wd);
        acc = rv && m_ready;
        if (m_pending) begin
            m_req     = exp_q.pop_front();
            m_valid   = 1'b1;
            m_pending = 1'b0;
        end else if (m_valid && ordy) begin
            m_valid = 1'b0;
        end
        if (acc) begin
            exp_q.push_back('{rs1: r1, rs2: r2, tag: tg});
            m_pending = 1'b1;
        end
        if (exp_we) arch[wa] = wd;
        @(negedge clk);
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 4'd0, 32'd0, ordy);
    endtask

    task automatic wb_only(input logic [3:0] wa, input logic [31:0] wd, input logic ordy);
        step(1'b0, 4'd0, 4'd0, 4'd0, 1'b1, wa, wd, ordy);
    endtask

    task automatic mid_reset();
        rst_n     = 1'b0;
        req_valid = 1'b0;
        wb_valid  = 1'b1;
        wb_addr   = 4'd3;
        wb_data   = $urandom;
        #1;
        check("rst_op_valid", {31'd0, op_valid}, 32'd0);
        check("rst_op_a", op_a, 32'd0);
        check("rst_op_tag", {28'd0, op_tag}, 32'd0);
        check("rst_we", {31'd0, rf_write_enable}, 32'd0);
        @(negedge clk);
        wb_valid = 1'b0;
        rst_n    = 1'b1;
        #1;
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        m_valid   = 1'b0;
        m_pending = 1'b0;
        exp_q.delete();
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) arch[i] = 32'd0;
        m_req     = '0;
        m_valid   = 1'b0;
        m_pending = 1'b0;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_rs1   = 4'd0;
        req_rs2   = 4'd0;
        req_tag   = 4'd0;
        wb_valid  = 1'b0;
        wb_addr   = 4'd0;
        wb_data   = 32'd0;
        op_ready  = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_op_valid", {31'd0, op_valid}, 32'd0);
        check("reset_op_a", op_a, 32'd0);
        check("reset_op_b", op_b, 32'd0);
        check("reset_op_tag", {28'd0, op_tag}, 32'd0);
        check("reset_we", {31'd0, rf_write_enable}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Preload every register through the writeback path.
        for (int i = 0; i < 16; i++) wb_only(4'(i), $urandom, 1'b1);
        wb_only(4'd3, 32'h11, 1'b1);
        wb_only(4'd5, 32'h22, 1'b1);
        wb_only(4'd4, 32'h1, 1'b1);
        idle(1'b1);

        // Plain read.
        step(1'b1, 4'd3, 4'd5, 4'd7, 1'b0, 4'd0, 32'd0, 1'b1);
        idle(1'b1);
        check("plain_valid", {31'd0, op_valid}, 32'd1);
        check("plain_a", op_a, 32'h11);
        check("plain_b", op_b, 32'h22);
        check("plain_tag", {28'd0, op_tag}, 32'd7);
        idle(1'b1);

        // Writeback in the accept cycle.
        step(1'b1, 4'd4, 4'd5, 4'd1, 1'b1, 4'd4, 32'hDEAD, 1'b1);
        idle(1'b1);
        check("samecyc_fwd_a", op_a, 32'hDEAD);
        idle(1'b1);

        // Writeback in the capture cycle.
        step(1'b1, 4'd1, 4'd6, 4'd2, 1'b0, 4'd0, 32'd0, 1'b1);
        wb_only(4'd6, 32'hBEEF, 1'b1);
        check("capture_fwd_b", op_b, 32'hBEEF);
        idle(1'b1);

        // Stall with a writeback to a held source.
        step(1'b1, 4'd2, 4'd5, 4'd3, 1'b0, 4'd0, 32'd0, 1'b1);
        idle(1'b0);
        idle(1'b0);
        idle(1'b0);
        wb_only(4'd2, 32'h55, 1'b0);
        check("stall_valid", {31'd0, op_valid}, 32'd1);
        check("stall_a", op_a, 32'h55);
        check("stall_b", op_b, 32'h22);
        check("stall_tag", {28'd0, op_tag}, 32'd3);
        idle(1'b0);
        idle(1'b1);

        // Back-to-back, with rs1 == rs2 on the second request.
        step(1'b1, 4'd3, 4'd5, 4'd8, 1'b0, 4'd0, 32'd0, 1'b1);
        idle(1'b1);
        step(1'b1, 4'd6, 4'd6, 4'd9, 1'b0, 4'd0, 32'd0, 1'b1);
        idle(1'b1);
        check("b2b_tag", {28'd0, op_tag}, 32'd9);
        check("b2b_same_src", op_a, 32'hBEEF);
        idle(1'b1);

        // Reset while in FETCH.
        step(1'b1, 4'd3, 4'd5, 4'hA, 1'b0, 4'd0, 32'd0, 1'b1);
        mid_reset();
        idle(1'b1);

`ifdef OFU_ZERO_REG_EN
        wb_valid = 1'b1;
        wb_addr  = 4'd0;
        wb_data  = 32'hFF;
        #1;
        check("zero_we", {31'd0, rf_write_enable}, 32'd0);
        wb_valid = 1'b0;
        step(1'b1, 4'd0, 4'd3, 4'd5, 1'b1, 4'd0, 32'hFF, 1'b1);
        idle(1'b1);
        check("zero_op_a", op_a, 32'd0);
        idle(1'b1);
`endif

        // Random traffic concentrated on a few registers to provoke hits.
        for (int i = 0; i < 800; i++) begin
            step($urandom_range(0, 9) < 7,
                 4'($urandom_range(0, 7)),
                 4'($urandom_range(0, 7)),
                 4'($urandom_range(0, 15)),
                 $urandom_range(0, 1) == 1,
                 ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15)),
                 $urandom,
                 $urandom_range(0, 9) < 6);
        end
        repeat (4) idle(1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
